// File: rtl/tlk2711_axil_reg_bridge.sv
// tlk2711_axil_reg_bridge: AXI4-Lite slave that serializes PS accesses onto the
// single-cycle strobe register bus of the TLK2711 register manager.
module tlk2711_axil_reg_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [63:0]           s_axi_wdata,
   input  logic [7:0]            s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [63:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic                  o_reg_wen,
   output logic [15:0]           o_reg_waddr,
   output logic [63:0]           o_reg_wdata,
   output logic                  o_reg_ren,
   output logic [15:0]           o_reg_raddr,
   input  logic [63:0]           i_reg_rdata
);
   typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP} state_t;
   state_t state_q, state_d;
   logic aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
   logic [63:0] w_data_q;
   logic [7:0] w_strb_q;
   logic err_q, err_d, wr_last_q, wr_last_d;
   logic [2:0] cnt_q, cnt_d;
   logic [15:0] reg_waddr_q, reg_waddr_d, reg_raddr_q, reg_raddr_d;
   logic [63:0] reg_wdata_q, reg_wdata_d, rdata_q, rdata_d;
   logic aw_hs, w_hs, ar_hs, b_hs, r_hs, wr_err, rd_err, wr_pend, rd_pend;

   // readies are gated by rst_n so they drop the moment reset asserts
   assign s_axi_awready = rst_n && !aw_full_q;
   assign s_axi_wready  = rst_n && !w_full_q;
   assign s_axi_arready = rst_n && !ar_full_q;
   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;
   assign b_hs  = s_axi_bvalid && s_axi_bready;
   assign r_hs  = s_axi_rvalid && s_axi_rready;
   assign wr_pend = aw_full_q && w_full_q;
   assign rd_pend = ar_full_q;
   assign wr_err = (aw_addr_q >> 16) != '0 || aw_addr_q[2:0] != 3'd0 || w_strb_q != 8'hFF;
   assign rd_err = (ar_addr_q >> 16) != '0 || ar_addr_q[2:0] != 3'd0;
   assign aw_full_d = (aw_full_q && !b_hs) || aw_hs;
   assign w_full_d  = (w_full_q && !b_hs) || w_hs;
   assign ar_full_d = (ar_full_q && !r_hs) || ar_hs;
   assign o_reg_wen    = state_q == WR_ISSUE && !err_q;
   assign o_reg_ren    = state_q == RD_ISSUE && !err_q;
   assign o_reg_waddr  = reg_waddr_q;
   assign o_reg_wdata  = reg_wdata_q;
   assign o_reg_raddr  = reg_raddr_q;
   assign s_axi_bvalid = state_q == WR_RESP;
   assign s_axi_bresp  = (s_axi_bvalid && err_q) ? 2'b10 : 2'b00;
   assign s_axi_rvalid = state_q == RD_RESP;
   assign s_axi_rresp  = (s_axi_rvalid && err_q) ? 2'b10 : 2'b00;
   assign s_axi_rdata  = rdata_q;

   always_comb begin
      state_d = state_q;
      err_d = err_q;
      wr_last_d = wr_last_q;
      cnt_d = cnt_q;
      reg_waddr_d = reg_waddr_q;
      reg_wdata_d = reg_wdata_q;
      reg_raddr_d = reg_raddr_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE:
            // wr_last alternates priority when both directions are pending
            if (wr_pend && (!rd_pend || !wr_last_q)) begin
               state_d = WR_ISSUE;
               err_d = wr_err;
               reg_waddr_d = wr_err ? reg_waddr_q : aw_addr_q[15:0];
               reg_wdata_d = wr_err ? reg_wdata_q : w_data_q;
            end else if (rd_pend) begin
               state_d = RD_ISSUE;
               err_d = rd_err;
               reg_raddr_d = rd_err ? reg_raddr_q : ar_addr_q[15:0];
            end
         WR_ISSUE: begin
            wr_last_d = 1'b1;
            state_d = WR_RESP;
         end
         WR_RESP: state_d = s_axi_bready ? IDLE : WR_RESP;
         RD_ISSUE: begin
            wr_last_d = 1'b0;
            cnt_d = 3'(RD_LATENCY);
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               rdata_d = err_q ? 64'h0 : i_reg_rdata;
               state_d = RD_RESP;
            end
         end
         RD_RESP: state_d = s_axi_rready ? IDLE : RD_RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         aw_full_q <= 1'b0;
         w_full_q <= 1'b0;
         ar_full_q <= 1'b0;
         aw_addr_q <= '0;
         ar_addr_q <= '0;
         w_data_q <= '0;
         w_strb_q <= '0;
         err_q <= 1'b0;
         wr_last_q <= 1'b0;
         cnt_q <= '0;
         reg_waddr_q <= '0;
         reg_wdata_q <= '0;
         reg_raddr_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         aw_full_q <= aw_full_d;
         w_full_q <= w_full_d;
         ar_full_q <= ar_full_d;
         if (aw_hs) aw_addr_q <= s_axi_awaddr;
         if (ar_hs) ar_addr_q <= s_axi_araddr;
         if (w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
         end
         err_q <= err_d;
         wr_last_q <= wr_last_d;
         cnt_q <= cnt_d;
         reg_waddr_q <= reg_waddr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_raddr_q <= reg_raddr_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_tlk2711_axil_reg_bridge.sv
// tb_tlk2711_axil_reg_bridge: vector table, corner sequences and randomized
// traffic against an array-based register model of the bridge.
module tb_tlk2711_axil_reg_bridge;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0;
   logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
   logic s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
   logic [63:0] s_axi_wdata = '0, i_reg_rdata = '0;
   logic [7:0] s_axi_wstrb = '0;
   logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
   logic [1:0] s_axi_bresp, s_axi_rresp;
   logic [63:0] s_axi_rdata, o_reg_wdata;
   logic o_reg_wen, o_reg_ren;
   logic [15:0] o_reg_waddr, o_reg_raddr;
   int checks = 0, errors = 0, cyc = 0;
   logic [79:0] wlog[$];
   logic [15:0] rlog[$];
   int seq[$];
   logic [63:0] exp_regs [8192];
   logic [63:0] env_regs [8192];

   tlk2711_axil_reg_bridge #(.ADDR_WIDTH(32), .RD_LATENCY(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
      .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] dflt(input int i);
      return {32'hC0DE_0000 | 32'(i), 32'h0BAD_0000 ^ 32'(i)};
   endfunction

   function automatic int seq_at(input int k);
      return (k < seq.size()) ? seq[k] : 0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // register-manager stub: data shows up RD_LATENCY=1 cycle after ren, junk otherwise
   initial begin
      logic [63:0] nxt;
      for (int i = 0; i < 8192; i++) env_regs[i] = dflt(i);
      env_regs[32] = 64'h2000_0000_0036_0366;
      forever begin
         @(negedge clk);
         nxt = o_reg_ren ? env_regs[o_reg_raddr[15:3]] : {$urandom, $urandom};
         if (o_reg_wen) env_regs[o_reg_waddr[15:3]] = o_reg_wdata;
         @(posedge clk);
         #1 i_reg_rdata = nxt;
      end
   end

   // strobe log and protocol monitor
   initial begin
      logic pwen = 0, pren = 0, prv = 0, prr = 0, pbv = 0, pbr = 0, rd_flag = 0;
      logic [63:0] prd = '0;
      logic [1:0] pbresp = '0;
      int ren_cyc = 0;
      forever begin
         @(negedge clk);
         #1 cyc++;
         if (o_reg_wen || o_reg_ren) chk("strobe_excl", 64'(o_reg_wen && o_reg_ren), 0);
         if (o_reg_wen) begin
            chk("wen_width", 64'(pwen), 0);
            wlog.push_back({o_reg_waddr, o_reg_wdata});
            seq.push_back(1);
         end
         if (o_reg_ren) begin
            chk("ren_width", 64'(pren), 0);
            rlog.push_back(o_reg_raddr);
            seq.push_back(2);
            ren_cyc = cyc;
            rd_flag = 1;
         end
         if (s_axi_rvalid && !prv && rd_flag) begin
            chk("rd_latency", 64'(cyc - ren_cyc), 2);
            rd_flag = 0;
         end
         if (prv && !prr && rst_n) begin
            chk("rvalid_hold", 64'(s_axi_rvalid), 1);
            chk("rdata_hold", s_axi_rdata, prd);
         end
         if (pbv && !pbr && rst_n) begin
            chk("bvalid_hold", 64'(s_axi_bvalid), 1);
            chk("bresp_hold", 64'(s_axi_bresp), 64'(pbresp));
         end
         pwen = o_reg_wen; pren = o_reg_ren; prv = s_axi_rvalid; prr = s_axi_rready;
         pbv = s_axi_bvalid; pbr = s_axi_bready; prd = s_axi_rdata; pbresp = s_axi_bresp;
      end
   end

   task automatic send_aw(input logic [31:0] a);
      int n = 0;
      s_axi_awaddr = a; s_axi_awvalid = 1'b1;
      while (!s_axi_awready && n < 100) begin @(negedge clk); n++; end
      if (n == 100) chk("aw_timeout", 1, 0);
      @(negedge clk); s_axi_awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [63:0] d, input logic [7:0] s);
      int n = 0;
      s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
      while (!s_axi_wready && n < 100) begin @(negedge clk); n++; end
      if (n == 100) chk("w_timeout", 1, 0);
      @(negedge clk); s_axi_wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] a);
      int n = 0;
      s_axi_araddr = a; s_axi_arvalid = 1'b1;
      while (!s_axi_arready && n < 100) begin @(negedge clk); n++; end
      if (n == 100) chk("ar_timeout", 1, 0);
      @(negedge clk); s_axi_arvalid = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
      int n = 0;
      fork
         begin repeat (aw_dly) @(negedge clk); send_aw(a); end
         begin repeat (w_dly) @(negedge clk); send_w(d, s); end
      join
      s_axi_bready = (b_dly == 0);
      while (!s_axi_bvalid && n < 200) begin @(negedge clk); n++; end
      if (n == 200) chk("b_timeout", 1, 0);
      repeat (b_dly) @(negedge clk);
      s_axi_bready = 1'b1;
      resp = s_axi_bresp;
      @(negedge clk); s_axi_bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, input int ar_dly, input int r_dly,
                          output logic [63:0] data, output logic [1:0] resp);
      int n = 0;
      repeat (ar_dly) @(negedge clk);
      send_ar(a);
      s_axi_rready = (r_dly == 0);
      while (!s_axi_rvalid && n < 200) begin @(negedge clk); n++; end
      if (n == 200) chk("r_timeout", 1, 0);
      repeat (r_dly) @(negedge clk);
      s_axi_rready = 1'b1;
      data = s_axi_rdata; resp = s_axi_rresp;
      @(negedge clk); s_axi_rready = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0; s_axi_bready = 0; s_axi_rready = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   typedef struct packed {
      logic        rd;
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
      logic [7:0]  dly;
      logic [1:0]  resp;
      logic        strobe;
      logic [63:0] rdata;
   } vec_t;

   initial begin
      vec_t vec [10];
      logic [63:0] rd, rd2;
      logic [1:0] rsp, rsp2;
      int nw, nr, ns, hits;
      for (int i = 0; i < 8192; i++) exp_regs[i] = dflt(i);
      exp_regs[32] = 64'h2000_0000_0036_0366;
      vec[0] = '{0, 32'h0000_0108, 64'h0000_0000_8000_0000, 8'hFF, 8'd0, 2'b00, 1, 64'h0};
      vec[1] = '{0, 32'h0001_0000, 64'h1111, 8'hFF, 8'd0, 2'b10, 0, 64'h0};
      vec[2] = '{0, 32'h0000_0010, 64'h2222, 8'h0F, 8'd2, 2'b10, 0, 64'h0};
      vec[3] = '{0, 32'h0000_000C, 64'h3333, 8'hFF, 8'd0, 2'b10, 0, 64'h0};
      vec[4] = '{0, 32'h0000_FFF8, 64'hDEAD_BEEF_0123_4567, 8'hFF, 8'd3, 2'b00, 1, 64'h0};
      vec[5] = '{1, 32'h0000_0100, 64'h0, 8'h0, 8'd5, 2'b00, 1, 64'h2000_0000_0036_0366};
      vec[6] = '{1, 32'h0000_0104, 64'h0, 8'h0, 8'd0, 2'b10, 0, 64'h0};
      vec[7] = '{1, 32'h0000_0108, 64'h0, 8'h0, 8'd1, 2'b00, 1, 64'h0000_0000_8000_0000};
      vec[8] = '{1, 32'h8000_0108, 64'h0, 8'h0, 8'd0, 2'b10, 0, 64'h0};
      vec[9] = '{1, 32'h0000_FFF8, 64'h0, 8'h0, 8'd2, 2'b00, 1, 64'hDEAD_BEEF_0123_4567};
      @(negedge clk);
      #1;
      chk("rst_awready", 64'(s_axi_awready), 0);
      chk("rst_wready", 64'(s_axi_wready), 0);
      chk("rst_arready", 64'(s_axi_arready), 0);
      chk("rst_valids", {62'b0, s_axi_bvalid, s_axi_rvalid}, 0);
      chk("rst_strobes", {62'b0, o_reg_wen, o_reg_ren}, 0);
      chk("rst_waddr_raddr", {32'b0, o_reg_waddr, o_reg_raddr}, 0);
      chk("rst_wdata", o_reg_wdata, 0);
      chk("rst_rdata", s_axi_rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_readies", {61'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'h7);
      for (int i = 0; i < 10; i++) begin
         nw = wlog.size(); nr = rlog.size();
         if (vec[i].rd) begin
            do_read(vec[i].addr, 0, int'(vec[i].dly), rd, rsp);
            chk($sformatf("v%0d_rresp", i), 64'(rsp), 64'(vec[i].resp));
            chk($sformatf("v%0d_rdata", i), rd, vec[i].rdata);
            chk($sformatf("v%0d_ren_count", i), 64'(rlog.size() - nr), 64'(vec[i].strobe));
            if (vec[i].strobe && rlog.size() > nr) chk($sformatf("v%0d_raddr", i), 64'(rlog[$]), 64'(vec[i].addr[15:0]));
         end else begin
            do_write(vec[i].addr, vec[i].data, vec[i].strb, 0, 0, int'(vec[i].dly), rsp);
            chk($sformatf("v%0d_bresp", i), 64'(rsp), 64'(vec[i].resp));
            chk($sformatf("v%0d_wen_count", i), 64'(wlog.size() - nw), 64'(vec[i].strobe));
            if (vec[i].strobe && wlog.size() > nw) chk($sformatf("v%0d_wstrobe", i), wlog[$][79:16], {vec[i].addr[15:0], vec[i].data[63:16]});
            if (vec[i].strobe && wlog.size() > nw) chk($sformatf("v%0d_wdata_lo", i), 64'(wlog[$][15:0]), 64'(vec[i].data[15:0]));
            if (vec[i].strobe) exp_regs[vec[i].addr[15:3]] = vec[i].data;
         end
      end
      // W leads AW by three cycles: exactly one strobe, only once AW lands
      nw = wlog.size();
      do_write(32'h8, 64'h0123_4567_89AB_CDEF, 8'hFF, 3, 0, 0, rsp);
      chk("wlead_bresp", 64'(rsp), 0);
      chk("wlead_wen_count", 64'(wlog.size() - nw), 1);
      if (wlog.size() > nw) chk("wlead_waddr", 64'(wlog[$][79:64]), 64'h8);
      exp_regs[1] = 64'h0123_4567_89AB_CDEF;
      // both pending straight out of reset: write goes first
      apply_reset();
      ns = seq.size();
      fork
         do_write(32'h210, 64'hAAAA_0000_0000_0210, 8'hFF, 0, 0, 0, rsp);
         do_read(32'h218, 0, 0, rd, rsp2);
      join
      exp_regs[32'h210 >> 3] = 64'hAAAA_0000_0000_0210;
      chk("alt1_first", 64'(seq_at(ns)), 1);
      chk("alt1_second", 64'(seq_at(ns + 1)), 2);
      chk("alt1_rdata", rd, exp_regs[32'h218 >> 3]);
      chk("alt1_resps", {60'b0, rsp, rsp2}, 0);
      // after a write, both pending again: read wins
      do_write(32'h220, 64'hBBBB_0000_0000_0220, 8'hFF, 0, 0, 0, rsp);
      exp_regs[32'h220 >> 3] = 64'hBBBB_0000_0000_0220;
      ns = seq.size();
      fork
         do_write(32'h228, 64'hCCCC_0000_0000_0228, 8'hFF, 0, 0, 0, rsp);
         do_read(32'h210, 0, 0, rd, rsp2);
      join
      exp_regs[32'h228 >> 3] = 64'hCCCC_0000_0000_0228;
      chk("alt2_first", 64'(seq_at(ns)), 2);
      chk("alt2_second", 64'(seq_at(ns + 1)), 1);
      chk("alt2_rdata", rd, 64'hAAAA_0000_0000_0210);
      // reset while the read waits for data: drop it silently
      s_axi_araddr = 32'h108; s_axi_arvalid = 1'b1;
      @(negedge clk); s_axi_arvalid = 1'b0;
      nr = 0;
      while (!o_reg_ren && nr < 20) begin @(negedge clk); nr++; end
      chk("rstmid_ren_seen", 64'(o_reg_ren), 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_readies", {61'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 0);
      chk("rstmid_valids", {62'b0, s_axi_bvalid, s_axi_rvalid}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nw = wlog.size(); nr = rlog.size(); hits = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); #2 if (s_axi_rvalid || s_axi_bvalid) hits++; end
      chk("rstmid_no_resp", 64'(hits), 0);
      chk("rstmid_no_strobe", 64'(wlog.size() - nw + rlog.size() - nr), 0);
      @(negedge clk);
      do_read(32'h108, 0, 1, rd2, rsp2);
      chk("rstmid_next_read", rd2, 64'h0000_0000_8000_0000);
      chk("rstmid_next_rresp", 64'(rsp2), 0);
      // random traffic against the array model
      for (int t = 0; t < 60; t++) begin
         logic [31:0] a;
         logic [63:0] d;
         logic [7:0] s;
         logic err, is_rd;
         int kind;
         kind = $urandom_range(0, 9);
         a = 32'h200 + 32'($urandom_range(0, 15)) * 8;
         if (kind == 7) a += 4;
         else if (kind == 8) a |= 32'h0001_0000;
         else if (kind == 9) a |= 32'h8000_0000;
         is_rd = 1'($urandom_range(0, 1));
         d = {$urandom, $urandom};
         s = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'hFF;
         err = (a >> 16) != 0 || a % 8 != 0 || (!is_rd && s != 8'hFF);
         nw = wlog.size(); nr = rlog.size();
         if (is_rd) begin
            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), rd, rsp);
            chk($sformatf("rnd%0d_rresp", t), 64'(rsp), err ? 64'h2 : 64'h0);
            chk($sformatf("rnd%0d_rdata", t), rd, err ? 64'h0 : exp_regs[a[15:3]]);
            chk($sformatf("rnd%0d_ren_count", t), 64'(rlog.size() - nr), 64'(!err));
         end else begin
            do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rsp);
            chk($sformatf("rnd%0d_bresp", t), 64'(rsp), err ? 64'h2 : 64'h0);
            chk($sformatf("rnd%0d_wen_count", t), 64'(wlog.size() - nw), 64'(!err));
            if (!err && wlog.size() > nw) chk($sformatf("rnd%0d_wdata", t), wlog[$][63:0], d);
            if (!err) exp_regs[a[15:3]] = d;
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
